// File: rtl/id_stage_piped_if.sv
// id_stage_piped_if: decode-stage bus between IF/ID, hazard unit, write-back and EX
// Inputs to the stage: pc_in, instruction_in, instr_valid_in, status_register, reg_file_wb_*,
//   hazard, stall, flush.
// Outputs from the stage: two_src, reg_file_*_src_out, ignore_hazard_out (combinational) and the
//   ID/EX register fields valid_out .. shift_operand.
// master drives the stage inputs, slave is the decode stage itself.
interface id_stage_piped_if #(parameter int DATA_W = 32, parameter int PC_W = 32);
  logic [PC_W-1:0]   pc_in;
  logic [31:0]       instruction_in;
  logic              instr_valid_in;
  logic [3:0]        status_register;
  logic [DATA_W-1:0] reg_file_wb_data;
  logic [3:0]        reg_file_wb_address;
  logic              reg_file_wb_en;
  logic              hazard;
  logic              stall;
  logic              flush;
  logic              two_src;
  logic [3:0]        reg_file_first_src_out;
  logic [3:0]        reg_file_second_src_out;
  logic              ignore_hazard_out;
  logic              valid_out;
  logic [PC_W-1:0]   pc_out;
  logic [3:0]        execute_command_out;
  logic              mem_read_en_out;
  logic              mem_write_en_out;
  logic              wb_enable_out;
  logic              immediate_out;
  logic              branch_taken_out;
  logic              status_write_enable_out;
  logic [DATA_W-1:0] reg_file_out1;
  logic [DATA_W-1:0] reg_file_out2;
  logic [3:0]        dest_reg_out;
  logic [23:0]       signed_immediate;
  logic [11:0]       shift_operand;
  modport master (
    output pc_in, instruction_in, instr_valid_in, status_register, reg_file_wb_data,
           reg_file_wb_address, reg_file_wb_en, hazard, stall, flush,
    input  two_src, reg_file_first_src_out, reg_file_second_src_out, ignore_hazard_out,
           valid_out, pc_out, execute_command_out, mem_read_en_out, mem_write_en_out,
           wb_enable_out, immediate_out, branch_taken_out, status_write_enable_out,
           reg_file_out1, reg_file_out2, dest_reg_out, signed_immediate, shift_operand
  );
  modport slave (
    input  pc_in, instruction_in, instr_valid_in, status_register, reg_file_wb_data,
           reg_file_wb_address, reg_file_wb_en, hazard, stall, flush,
    output two_src, reg_file_first_src_out, reg_file_second_src_out, ignore_hazard_out,
           valid_out, pc_out, execute_command_out, mem_read_en_out, mem_write_en_out,
           wb_enable_out, immediate_out, branch_taken_out, status_write_enable_out,
           reg_file_out1, reg_file_out2, dest_reg_out, signed_immediate, shift_operand
  );
endinterface

// File: rtl/id_stage_piped.sv
// id_stage_piped: ARM decode stage with register file, condition check and ID/EX register
// Ports: clk, rst (synchronous, active-low), bus (id_stage_piped_if.slave).
// Optional macro WB_BYPASS_EN: forward same-cycle write-back data to the operand reads.
// Control word order: {exe_cmd[3:0], mem_read, mem_write, wb, imm, branch, status_write}.
// Controller: mode 00 MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR write back, CMP/TST only set flags;
//   mode 01 LDR (S=1) / STR (S=0) with exe_cmd ADD; mode 10 branch.
module id_stage_piped #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int NUM_REGS = 16
) (
  input logic clk,
  input logic rst,
  id_stage_piped_if.slave bus
);
`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  localparam logic [4:0] NR = 5'(NUM_REGS);
  logic [DATA_W-1:0] r_regs [16];
  logic              r_valid;
  logic [9:0]        r_ctrl;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic [3:0]        r_dest;
  logic [23:0]       r_simm;
  logic [11:0]       r_shift;
  logic [31:0]       w_ins;
  logic [3:0]        w_exe, w_a1, w_a2;
  logic              w_mr, w_mw, w_wb, w_br, w_sw, w_ign, w_base, w_cond, w_live;
  logic              w_n, w_z, w_c, w_v;
  logic [9:0]        w_ctrl;
  logic [DATA_W-1:0] w_op1, w_op2;
  assign w_ins = bus.instruction_in;
  assign {w_n, w_z, w_c, w_v} = bus.status_register;
  always_comb begin
    w_exe = 4'b0000;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_wb  = 1'b0;
    w_br  = 1'b0;
    w_sw  = 1'b0;
    w_ign = 1'b0;
    case (w_ins[27:26])
      2'b00: begin
        w_sw = w_ins[20];
        w_wb = 1'b1;
        case (w_ins[24:21])
          4'b1101: begin w_exe = 4'b0001; w_ign = 1'b1; end
          4'b1111: begin w_exe = 4'b1001; w_ign = 1'b1; end
          4'b0100: w_exe = 4'b0010;
          4'b0101: w_exe = 4'b0011;
          4'b0010: w_exe = 4'b0100;
          4'b0110: w_exe = 4'b0101;
          4'b0000: w_exe = 4'b0110;
          4'b1100: w_exe = 4'b0111;
          4'b0001: w_exe = 4'b1000;
          4'b1010: begin w_exe = 4'b0100; w_wb = 1'b0; end
          4'b1000: begin w_exe = 4'b0110; w_wb = 1'b0; end
          default: begin w_wb = 1'b0; w_sw = 1'b0; end
        endcase
      end
      2'b01: begin
        w_exe = 4'b0010;
        w_mr  = w_ins[20];
        w_mw  = ~w_ins[20];
        w_wb  = w_ins[20];
      end
      2'b10: begin w_br = 1'b1; w_ign = 1'b1; end
      default: w_exe = 4'b0000;
    endcase
  end
  assign w_ctrl = {w_exe, w_mr, w_mw, w_wb, w_ins[25], w_br, w_sw};
  // Conditions come in pairs: odd codes invert the even one, except 111x (AL / never).
  always_comb begin
    case (w_ins[31:29])
      3'b000:  w_base = w_z;
      3'b001:  w_base = w_c;
      3'b010:  w_base = w_n;
      3'b011:  w_base = w_v;
      3'b100:  w_base = w_c & ~w_z;
      3'b101:  w_base = w_n == w_v;
      3'b110:  w_base = ~w_z & (w_n == w_v);
      default: w_base = 1'b1;
    endcase
  end
  assign w_cond = &w_ins[31:29] ? ~w_ins[28] : w_base ^ w_ins[28];
  assign w_live = bus.instr_valid_in & ~bus.hazard & w_cond;
  assign w_a1 = w_ins[19:16];
  assign w_a2 = w_mw ? w_ins[15:12] : w_ins[3:0];
  assign w_op1 = ({1'b0, w_a1} >= NR) ? '0 :
                 (BYP && bus.reg_file_wb_en && bus.reg_file_wb_address == w_a1) ? bus.reg_file_wb_data :
                 r_regs[w_a1];
  assign w_op2 = ({1'b0, w_a2} >= NR) ? '0 :
                 (BYP && bus.reg_file_wb_en && bus.reg_file_wb_address == w_a2) ? bus.reg_file_wb_data :
                 r_regs[w_a2];
  assign bus.two_src                 = bus.instr_valid_in & (~w_ins[25] | w_mw);
  assign bus.reg_file_first_src_out  = bus.instr_valid_in ? w_a1 : 4'h0;
  assign bus.reg_file_second_src_out = bus.instr_valid_in ? w_a2 : 4'h0;
  assign bus.ignore_hazard_out       = bus.instr_valid_in & w_ign;
  always_ff @(posedge clk) begin
    if (!rst)
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    else if (bus.reg_file_wb_en && {1'b0, bus.reg_file_wb_address} < NR)
      r_regs[bus.reg_file_wb_address] <= bus.reg_file_wb_data;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_dest  <= '0;
      r_simm  <= '0;
      r_shift <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (!bus.stall) begin
      r_valid <= w_live;
      r_ctrl  <= w_live ? w_ctrl : '0;
      r_pc    <= bus.pc_in;
      r_op1   <= w_op1;
      r_op2   <= w_op2;
      r_dest  <= w_ins[15:12];
      r_simm  <= w_ins[23:0];
      r_shift <= w_ins[11:0];
    end
  end
  assign bus.valid_out = r_valid;
  assign {bus.execute_command_out, bus.mem_read_en_out, bus.mem_write_en_out, bus.wb_enable_out,
          bus.immediate_out, bus.branch_taken_out, bus.status_write_enable_out} = r_ctrl;
  assign bus.pc_out           = r_pc;
  assign bus.reg_file_out1    = r_op1;
  assign bus.reg_file_out2    = r_op2;
  assign bus.dest_reg_out     = r_dest;
  assign bus.signed_immediate = r_simm;
  assign bus.shift_operand    = r_shift;
endmodule

// File: tb/tb_id_stage_piped.sv
// tb_id_stage_piped: table-driven check of decode, condition gating, stall/flush, bypass and reset
module tb_id_stage_piped;
  localparam logic [9:0] CADD = 10'b0010001000;
  localparam logic [9:0] CSTR = 10'b0010010000;
  localparam logic [9:0] CLDR = 10'b0010101000;
  localparam logic [9:0] CMOV = 10'b0001001100;
  localparam logic [9:0] CCMP = 10'b0100000001;
  localparam logic [9:0] CB   = 10'b0000000110;
  localparam logic [9:0] CMVN = 10'b1001001000;
  localparam logic [9:0] C0   = 10'b0000000000;
`ifdef WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hDEAD;
`else
  localparam logic [31:0] BYP_EXP = 32'd7;
`endif
  typedef struct {
    logic [31:0] ins;
    logic [3:0]  st;
    logic        hz;
    logic        vi;
    logic        two;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        ign;
    logic        vo;
    logic [9:0]  ctrl;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [3:0]  dst;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vt [14];
  logic [9:0] ctl;
  id_stage_piped_if #(.DATA_W(32), .PC_W(32)) bus ();
  id_stage_piped #(.DATA_W(32), .PC_W(32), .NUM_REGS(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  assign ctl = {bus.execute_command_out, bus.mem_read_en_out, bus.mem_write_en_out, bus.wb_enable_out,
                bus.immediate_out, bus.branch_taken_out, bus.status_write_enable_out};
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wb(input logic [3:0] a, input logic [31:0] d);
    bus.reg_file_wb_en = 1'b1;
    bus.reg_file_wb_address = a;
    bus.reg_file_wb_data = d;
    tick();
    bus.reg_file_wb_en = 1'b0;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, 64'(bus.valid_out), 64'(0));
    chk({nm, " ctrl"}, 64'(ctl), 64'(0));
    chk({nm, " pc"}, 64'(bus.pc_out), 64'(0));
    chk({nm, " out1"}, 64'(bus.reg_file_out1), 64'(0));
    chk({nm, " out2"}, 64'(bus.reg_file_out2), 64'(0));
    chk({nm, " dest"}, 64'(bus.dest_reg_out), 64'(0));
    chk({nm, " simm"}, 64'(bus.signed_immediate), 64'(0));
    chk({nm, " shift"}, 64'(bus.shift_operand), 64'(0));
  endtask
  initial begin
    vt[0]  = '{32'hE0813002, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 1'b1, CADD, 32'd5, 32'd7, 4'h3};
    vt[1]  = '{32'h00813002, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 1'b0, C0,   32'd5, 32'd7, 4'h3};
    vt[2]  = '{32'h00813002, 4'h4, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 1'b1, CADD, 32'd5, 32'd7, 4'h3};
    vt[3]  = '{32'hE5814000, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h4, 1'b0, 1'b1, CSTR, 32'd5, 32'h44, 4'h4};
    vt[4]  = '{32'hE5914000, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h0, 1'b0, 1'b1, CLDR, 32'd5, 32'd0, 4'h4};
    vt[5]  = '{32'hE3A05012, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h2, 1'b1, 1'b1, CMOV, 32'd0, 32'd7, 4'h5};
    vt[6]  = '{32'hE1510002, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 1'b1, CCMP, 32'd5, 32'd7, 4'h0};
    vt[7]  = '{32'hEA000010, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, CB,   32'd0, 32'd0, 4'h0};
    vt[8]  = '{32'hE0813002, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 1'b0, C0,   32'd5, 32'd7, 4'h3};
    vt[9]  = '{32'hE0813002, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, C0,   32'd5, 32'd7, 4'h3};
    vt[10] = '{32'hE08C3001, 4'h0, 1'b0, 1'b1, 1'b1, 4'hC, 4'h1, 1'b0, 1'b1, CADD, 32'd0, 32'd5, 4'h3};
    vt[11] = '{32'h10813002, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 1'b1, CADD, 32'd5, 32'd7, 4'h3};
    vt[12] = '{32'hA0813002, 4'h8, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 1'b0, C0,   32'd5, 32'd7, 4'h3};
    vt[13] = '{32'hE1E05001, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h1, 1'b1, 1'b1, CMVN, 32'd0, 32'd5, 4'h5};
    bus.pc_in = '0;
    bus.instruction_in = '0;
    bus.instr_valid_in = 1'b0;
    bus.status_register = '0;
    bus.reg_file_wb_data = '0;
    bus.reg_file_wb_address = '0;
    bus.reg_file_wb_en = 1'b0;
    bus.hazard = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b1;
    wb(4'd1, 32'd5);
    wb(4'd2, 32'd7);
    wb(4'd4, 32'h44);
    wb(4'd12, 32'd9);
    for (int i = 0; i < 14; i++) begin
      bus.instruction_in = vt[i].ins;
      bus.status_register = vt[i].st;
      bus.hazard = vt[i].hz;
      bus.instr_valid_in = vt[i].vi;
      bus.pc_in = 32'h100 + 32'(i * 4);
      #1;
      chk($sformatf("v%0d two_src", i), 64'(bus.two_src), 64'(vt[i].two));
      chk($sformatf("v%0d src1", i), 64'(bus.reg_file_first_src_out), 64'(vt[i].s1));
      chk($sformatf("v%0d src2", i), 64'(bus.reg_file_second_src_out), 64'(vt[i].s2));
      chk($sformatf("v%0d ign", i), 64'(bus.ignore_hazard_out), 64'(vt[i].ign));
      tick();
      chk($sformatf("v%0d valid", i), 64'(bus.valid_out), 64'(vt[i].vo));
      chk($sformatf("v%0d ctrl", i), 64'(ctl), 64'(vt[i].ctrl));
      chk($sformatf("v%0d out1", i), 64'(bus.reg_file_out1), 64'(vt[i].o1));
      chk($sformatf("v%0d out2", i), 64'(bus.reg_file_out2), 64'(vt[i].o2));
      chk($sformatf("v%0d dest", i), 64'(bus.dest_reg_out), 64'(vt[i].dst));
      chk($sformatf("v%0d pc", i), 64'(bus.pc_out), 64'(32'h100 + 32'(i * 4)));
      chk($sformatf("v%0d simm", i), 64'(bus.signed_immediate), 64'(vt[i].ins[23:0]));
      chk($sformatf("v%0d shift", i), 64'(bus.shift_operand), 64'(vt[i].ins[11:0]));
    end
    bus.hazard = 1'b0;
    bus.status_register = 4'h0;
    bus.instr_valid_in = 1'b1;
    bus.instruction_in = 32'hE0813002;
    bus.pc_in = 32'h200;
    tick();
    chk("pre-stall valid", 64'(bus.valid_out), 64'(1));
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.instruction_in = (k == 1) ? 32'hE5814000 : 32'hEA000010;
      bus.pc_in = 32'h300 + 32'(k);
      tick();
      chk($sformatf("stall%0d valid", k), 64'(bus.valid_out), 64'(1));
      chk($sformatf("stall%0d ctrl", k), 64'(ctl), 64'(CADD));
      chk($sformatf("stall%0d pc", k), 64'(bus.pc_out), 64'(32'h200));
      chk($sformatf("stall%0d dest", k), 64'(bus.dest_reg_out), 64'(3));
      chk($sformatf("stall%0d out2", k), 64'(bus.reg_file_out2), 64'(7));
    end
    bus.flush = 1'b1;
    tick();
    chk("flush valid", 64'(bus.valid_out), 64'(0));
    chk("flush ctrl", 64'(ctl), 64'(0));
    chk("flush pc hold", 64'(bus.pc_out), 64'(32'h200));
    chk("flush out1 hold", 64'(bus.reg_file_out1), 64'(5));
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    bus.instruction_in = 32'hE0813002;
    bus.pc_in = 32'h400;
    bus.reg_file_wb_en = 1'b1;
    bus.reg_file_wb_address = 4'd2;
    bus.reg_file_wb_data = 32'hDEAD;
    tick();
    bus.reg_file_wb_en = 1'b0;
    chk("bypass out2", 64'(bus.reg_file_out2), 64'(BYP_EXP));
    chk("bypass out1", 64'(bus.reg_file_out1), 64'(5));
    tick();
    chk("after wb out2", 64'(bus.reg_file_out2), 64'(32'hDEAD));
    chk("after wb valid", 64'(bus.valid_out), 64'(1));
    rst = 1'b0;
    bus.reg_file_wb_en = 1'b1;
    bus.reg_file_wb_address = 4'd1;
    bus.reg_file_wb_data = 32'h77;
    tick();
    chk_zero("mid reset");
    rst = 1'b1;
    bus.reg_file_wb_en = 1'b0;
    tick();
    chk("post reset valid", 64'(bus.valid_out), 64'(1));
    chk("post reset r1", 64'(bus.reg_file_out1), 64'(0));
    chk("post reset r2", 64'(bus.reg_file_out2), 64'(0));
    chk("post reset pc", 64'(bus.pc_out), 64'(32'h400));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
